// File: rtl/branch_resolve_predict.sv
// ----------------------------------------------------------------------------
// branch_resolve_predict
//
// Resolves MIPS conditional branches (beq, bne, blez, bgtz, bltz, bgez) at the
// ID/EX boundary. It registers the outcome, flags a mispredict against the
// prediction carried down from IF, and supplies the redirect PC. It also trains
// a table of 2-bit saturating counters that IF reads for next-PC prediction,
// and keeps saturating counts of resolved branches and of mispredicts.
//
// Ports
//   Clk, Rst          rising-edge clock, asynchronous active-high reset
//   PredPC            IF-stage PC used for the table lookup
//   PredTaken         combinational prediction (MSB of the indexed counter)
//   ResValid, Flush   resolution request; Flush kills it in the same cycle
//   ResPC             PC of the branch being resolved (selects the counter)
//   OpCode, Rt        instruction[31:26], instruction[20:16]
//   ReadData1/2       rs / rt operands
//   PredictedTaken    prediction made in IF for this branch
//   TakenTarget       branch target
//   FallThrough       not-taken continuation PC
//   OutValid          registered: result fields valid this cycle
//   IsBranch          registered: request decoded as a conditional branch
//   Taken             registered branch outcome
//   Mispredict        registered: outcome differs from PredictedTaken
//   RedirectPC        registered correct PC on a mispredict, else 0
//   BranchCount       saturating count of resolved branches
//   MispredictCount   saturating count of mispredicts
// ----------------------------------------------------------------------------
module branch_resolve_predict #(
   parameter int         DATA_WIDTH = 32,
   parameter int         PC_WIDTH   = 32,
   parameter int         BHT_DEPTH  = 64,
   parameter logic [1:0] CTR_INIT   = 2'b01
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [PC_WIDTH-1:0]   PredPC,
   output logic                  PredTaken,
   input  logic                  ResValid,
   input  logic                  Flush,
   input  logic [PC_WIDTH-1:0]   ResPC,
   input  logic [5:0]            OpCode,
   input  logic [4:0]            Rt,
   input  logic [DATA_WIDTH-1:0] ReadData1,
   input  logic [DATA_WIDTH-1:0] ReadData2,
   input  logic                  PredictedTaken,
   input  logic [PC_WIDTH-1:0]   TakenTarget,
   input  logic [PC_WIDTH-1:0]   FallThrough,
   output logic                  OutValid,
   output logic                  IsBranch,
   output logic                  Taken,
   output logic                  Mispredict,
   output logic [PC_WIDTH-1:0]   RedirectPC,
   output logic [31:0]           BranchCount,
   output logic [31:0]           MispredictCount
);

   localparam int          IDX     = $clog2(BHT_DEPTH);
   localparam logic [31:0] CNT_MAX = '1;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   logic [1:0]          r_bht [BHT_DEPTH];
   logic                r_out_valid;
   logic                r_is_branch;
   logic                r_taken;
   logic                r_mispredict;
   logic [PC_WIDTH-1:0] r_redirect_pc;
   logic [31:0]         r_branch_count;
   logic [31:0]         r_mispredict_count;

   logic [IDX-1:0]      w_pred_idx;
   logic [IDX-1:0]      w_res_idx;
   logic                w_rs_neg;
   logic                w_rs_zero;
   logic                w_is_branch;
   logic                w_cond;
   logic                w_branch;
   logic                w_mispredict;
   logic [1:0]          w_ctr_cur;
   logic [1:0]          w_ctr_next;
   logic                w_unused_pc_bits;

   // Word-aligned PCs: bits [1:0] never select an entry, high bits alias.
   assign w_pred_idx = PredPC[IDX+1:2];
   assign w_res_idx  = ResPC[IDX+1:2];
   assign w_unused_pc_bits = ^{PredPC[1:0], PredPC[PC_WIDTH-1:IDX+2],
                               ResPC[1:0],  ResPC[PC_WIDTH-1:IDX+2]};

   // Plain array read with no bypass: a same-cycle update is seen next cycle.
   assign PredTaken = r_bht[w_pred_idx][1];

   // Signed compares against zero reduce to the sign bit and a zero test.
   assign w_rs_neg  = ReadData1[DATA_WIDTH-1];
   assign w_rs_zero = (ReadData1 == '0);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_is_branch = 1'b0;
      w_cond      = 1'b0;
      case (OpCode)
         OP_BEQ:  begin w_is_branch = 1'b1; w_cond = (ReadData1 == ReadData2); end
         OP_BNE:  begin w_is_branch = 1'b1; w_cond = (ReadData1 != ReadData2); end
         OP_BLEZ: begin w_is_branch = 1'b1; w_cond = w_rs_neg | w_rs_zero;     end
         OP_BGTZ: begin w_is_branch = 1'b1; w_cond = ~w_rs_neg & ~w_rs_zero;   end
         OP_REGIMM: begin
            if (Rt == 5'b00000) begin
               w_is_branch = 1'b1;
               w_cond      = w_rs_neg;
            end else if (Rt == 5'b00001) begin
               w_is_branch = 1'b1;
               w_cond      = ~w_rs_neg;
            end
         end
         default: ;
      endcase
   end

   assign w_branch     = ResValid & ~Flush & w_is_branch;
   assign w_mispredict = w_branch & (w_cond != PredictedTaken);

   // 2-bit saturating counter step for the entry being resolved.
   assign w_ctr_cur = r_bht[w_res_idx];
   always_comb begin
      w_ctr_next = w_ctr_cur;
      if (w_cond && w_ctr_cur != 2'b11)
         w_ctr_next = w_ctr_cur + 2'd1;
      else if (!w_cond && w_ctr_cur != 2'b00)
         w_ctr_next = w_ctr_cur - 2'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_out_valid        <= 1'b0;
         r_is_branch        <= 1'b0;
         r_taken            <= 1'b0;
         r_mispredict       <= 1'b0;
         r_redirect_pc      <= '0;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
         // NOTE: the table is reset entry by entry because IF relies on a
         // known prediction from the first cycle; this keeps it in flops
         // rather than a RAM macro.
         for (int i = 0; i < BHT_DEPTH; i++)
            r_bht[i] <= CTR_INIT;
      end else begin
         r_out_valid   <= ResValid & ~Flush;
         r_is_branch   <= w_branch;
         r_taken       <= w_branch & w_cond;
         r_mispredict  <= w_mispredict;
         r_redirect_pc <= w_mispredict ? (w_cond ? TakenTarget : FallThrough) : '0;
         if (w_branch) begin
            r_bht[w_res_idx] <= w_ctr_next;
            if (r_branch_count != CNT_MAX)
               r_branch_count <= r_branch_count + 32'd1;
         end
         if (w_mispredict && r_mispredict_count != CNT_MAX)
            r_mispredict_count <= r_mispredict_count + 32'd1;
      end
   end

   assign OutValid        = r_out_valid;
   assign IsBranch        = r_is_branch;
   assign Taken           = r_taken;
   assign Mispredict      = r_mispredict;
   assign RedirectPC      = r_redirect_pc;
   assign BranchCount     = r_branch_count;
   assign MispredictCount = r_mispredict_count;

endmodule
